// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the systolic sort engine and its compare-exchange cells.
package sort_pkg;

  localparam int unsigned OUTPUT_BUF_DATASIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } sort_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned phase_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange cell: orders a {key, idx} pair; strict compare keeps equal keys in place.
// Defining SORT_SIGNED_EN switches the key compare to two's-complement signed.
module sort_cmp_swap #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [W-1:0]  lo_key_i,
  input  logic [IW-1:0] lo_idx_i,
  input  logic [W-1:0]  hi_key_i,
  input  logic [IW-1:0] hi_idx_i,
  input  logic          desc_i,
  output logic [W-1:0]  lo_key_c,
  output logic [IW-1:0] lo_idx_c,
  output logic [W-1:0]  hi_key_c,
  output logic [IW-1:0] hi_idx_c
);

  logic lo_gt;
  logic lo_lt;
  logic swap;

`ifdef SORT_SIGNED_EN
  assign lo_gt = $signed(lo_key_i) > $signed(hi_key_i);
  assign lo_lt = $signed(lo_key_i) < $signed(hi_key_i);
`else
  assign lo_gt = lo_key_i > hi_key_i;
  assign lo_lt = lo_key_i < hi_key_i;
`endif

  assign swap = desc_i ? lo_lt : lo_gt;

  assign lo_key_c = swap ? hi_key_i : lo_key_i;
  assign lo_idx_c = swap ? hi_idx_i : lo_idx_i;
  assign hi_key_c = swap ? lo_key_i : hi_key_i;
  assign hi_idx_c = swap ? lo_idx_i : hi_idx_i;

endmodule

// File: rtl/systolic_sort_engine.sv
// N-lane odd-even transposition sorter, one phase per enabled cycle, valid/ready on both sides.
// Signed key ordering is selected by defining SORT_SIGNED_EN (applied inside sort_cmp_swap).
module systolic_sort_engine
  import sort_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = OUTPUT_BUF_DATASIZE,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in,
  input  logic            desc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out,
  output logic [N*IW-1:0] out_idx,
  output logic [W-1:0]    max_out
);

  localparam int unsigned PW   = phase_width(N);
  localparam int unsigned NE   = N / 2;
  localparam int unsigned NO   = (N - 1) / 2;
  localparam int unsigned NO_A = (NO == 0) ? 1 : NO;

  sort_state_e   state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          desc_q, desc_d;
  logic [W-1:0]  key_q [N];
  logic [W-1:0]  key_d [N];
  logic [IW-1:0] idx_q [N];
  logic [IW-1:0] idx_d [N];

  logic [W-1:0]  ev_lo_k [NE];
  logic [W-1:0]  ev_hi_k [NE];
  logic [IW-1:0] ev_lo_i [NE];
  logic [IW-1:0] ev_hi_i [NE];
  logic [W-1:0]  od_lo_k [NO_A];
  logic [W-1:0]  od_hi_k [NO_A];
  logic [IW-1:0] od_lo_i [NO_A];
  logic [IW-1:0] od_hi_i [NO_A];

  logic [W-1:0]  net_k [N];
  logic [IW-1:0] net_i [N];
  logic          accept;
  logic          out_fire;

  // Even-phase cells pair (2k, 2k+1); odd-phase cells pair (2k+1, 2k+2).
  for (genvar k = 0; k < NE; k++) begin : g_even
    sort_cmp_swap #(.W(W), .IW(IW)) u_cs (
      .lo_key_i (key_q[2*k]),
      .lo_idx_i (idx_q[2*k]),
      .hi_key_i (key_q[2*k+1]),
      .hi_idx_i (idx_q[2*k+1]),
      .desc_i   (desc_q),
      .lo_key_c (ev_lo_k[k]),
      .lo_idx_c (ev_lo_i[k]),
      .hi_key_c (ev_hi_k[k]),
      .hi_idx_c (ev_hi_i[k])
    );
  end

  for (genvar k = 0; k < NO; k++) begin : g_odd
    sort_cmp_swap #(.W(W), .IW(IW)) u_cs (
      .lo_key_i (key_q[2*k+1]),
      .lo_idx_i (idx_q[2*k+1]),
      .hi_key_i (key_q[2*k+2]),
      .hi_idx_i (idx_q[2*k+2]),
      .desc_i   (desc_q),
      .lo_key_c (od_lo_k[k]),
      .lo_idx_c (od_lo_i[k]),
      .hi_key_c (od_hi_k[k]),
      .hi_idx_c (od_hi_i[k])
    );
  end

  // Phase network result, selected by phase parity; unpaired end lanes pass through.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      net_k[i] = key_q[i];
      net_i[i] = idx_q[i];
    end
    if (!phase_q[0]) begin
      for (int k = 0; k < int'(NE); k++) begin
        net_k[2*k]   = ev_lo_k[k];
        net_i[2*k]   = ev_lo_i[k];
        net_k[2*k+1] = ev_hi_k[k];
        net_i[2*k+1] = ev_hi_i[k];
      end
    end else begin
      for (int k = 0; k < int'(NO); k++) begin
        net_k[2*k+1] = od_lo_k[k];
        net_i[2*k+1] = od_lo_i[k];
        net_k[2*k+2] = od_hi_k[k];
        net_i[2*k+2] = od_hi_i[k];
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = en & in_valid & in_ready;
  assign out_fire  = en & out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    desc_d  = desc_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: ;
      ST_SORT: begin
        if (en) begin
          key_d   = net_k;
          idx_d   = net_i;
          phase_d = phase_q + PW'(1);
          if (phase_q == PW'(N - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new vector overrides the DONE->IDLE return so back-to-back runs skip the idle cycle.
    if (accept) begin
      for (int i = 0; i < int'(N); i++) begin
        key_d[i] = in[i*W +: W];
        idx_d[i] = IW'(i);
      end
      desc_d  = desc;
      phase_d = '0;
      state_d = ST_SORT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      desc_q  <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        key_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      desc_q  <= desc_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      out[i*W +: W]      = key_q[i];
      out_idx[i*IW +: IW] = idx_q[i];
    end
  end

  assign max_out = desc_q ? key_q[0] : key_q[N-1];

endmodule

// File: tb/tb_systolic_sort_engine.sv
// Self-checking bench for systolic_sort_engine (N=4, W=8) against a stable-selection-sort model.
module tb_systolic_sort_engine;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_bus;
  logic            desc;
  logic            out_valid;
  logic            out_ready;
  logic [N*W-1:0]  out;
  logic [N*IW-1:0] out_idx;
  logic [W-1:0]    max_out;

  int checks = 0;
  int errors = 0;

  systolic_sort_engine #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_bus),
    .desc      (desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_idx   (out_idx),
    .max_out   (max_out)
  );

  always #5 clk = ~clk;

  function automatic bit key_lt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SORT_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Stable selection sort: pick best remaining key, ties go to the lowest source lane.
  task automatic model_sort(input logic [N*W-1:0] vin, input bit d,
                            output logic [N*W-1:0] eo, output logic [N*IW-1:0] ei,
                            output logic [W-1:0] em);
    logic [W-1:0] k [N];
    bit used [N];
    int best;
    for (int i = 0; i < int'(N); i++) begin
      k[i] = vin[i*W +: W];
      used[i] = 1'b0;
    end
    em = k[0];
    for (int i = 1; i < int'(N); i++) if (key_lt(em, k[i])) em = k[i];
    eo = '0;
    ei = '0;
    for (int j = 0; j < int'(N); j++) begin
      best = -1;
      for (int i = 0; i < int'(N); i++) begin
        if (!used[i]) begin
          if (best < 0) best = i;
          else if (d ? key_lt(k[best], k[i]) : key_lt(k[i], k[best])) best = i;
        end
      end
      used[best] = 1'b1;
      eo[j*W +: W] = k[best];
      ei[j*IW +: IW] = IW'(best);
    end
  endtask

  task automatic do_accept(input logic [N*W-1:0] v, input bit d);
    int guard = 0;
    @(negedge clk);
    in_bus = v;
    desc = d;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bus = '0;
    @(negedge clk);
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_handshake got %b required 01", {out_valid, in_ready});
    end
    checks++;
    if ({out, out_idx, max_out} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h required 0", out, out_idx, max_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_asc();
    logic [N*W-1:0] v = {8'h03, 8'h07, 8'h01, 8'h05};
    int lat;
    do_accept(v, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL asc_latency got %0d required 4", lat); end
    checks++;
    if (out !== {8'h07, 8'h05, 8'h03, 8'h01}) begin
      errors++; $display("FAIL asc_out got %h required 07050301", out);
    end
    checks++;
    if (out_idx !== {2'd2, 2'd0, 2'd3, 2'd1}) begin
      errors++; $display("FAIL asc_idx got %b required 10001101", out_idx);
    end
    checks++;
    if (max_out !== 8'h07) begin errors++; $display("FAIL asc_max got %h required 07", max_out); end
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL asc_return_idle got %b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_desc_ties();
    logic [N*W-1:0] v = {8'h04, 8'h02, 8'h09, 8'h02};
    int lat;
    do_accept(v, 1'b1);
    wait_valid(lat);
    checks++;
    if (out !== {8'h02, 8'h02, 8'h04, 8'h09}) begin
      errors++; $display("FAIL desc_out got %h required 02020409", out);
    end
    checks++;
    if (out_idx !== {2'd2, 2'd0, 2'd3, 2'd1}) begin
      errors++; $display("FAIL desc_idx got %b required 10001101", out_idx);
    end
    checks++;
    if (max_out !== 8'h09) begin errors++; $display("FAIL desc_max got %h required 09", max_out); end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] v1, v2, eo1, eo2;
    logic [N*IW-1:0] ei1, ei2;
    logic [W-1:0] em1, em2;
    int lat;
    v1 = {$urandom, $urandom} & {(N*W){1'b1}};
    v2 = {$urandom, $urandom} & {(N*W){1'b1}};
    model_sort(v1, 1'b0, eo1, ei1, em1);
    model_sort(v2, 1'b1, eo2, ei2, em2);
    do_accept(v1, 1'b0);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid, in_ready, out, out_idx} !== {1'b1, 1'b0, eo1, ei1}) begin
        errors++;
        $display("FAIL backpressure_hold cyc %0d got v%b r%b %h/%h required v1 r0 %h/%h",
                 c, out_valid, in_ready, out, out_idx, eo1, ei1);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bus = v2;
    desc = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b required 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_bus = '0;
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++; $display("FAIL b2b_no_idle got %b required 00", {out_valid, in_ready});
    end
    @(negedge clk);
    wait_valid(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d required 4", lat); end
    checks++;
    if ({out, out_idx, max_out} !== {eo2, ei2, em2}) begin
      errors++; $display("FAIL b2b_result got %h/%h/%h required %h/%h/%h",
                         out, out_idx, max_out, eo2, ei2, em2);
    end
    release_out();
  endtask

  task automatic test_stall();
    logic [N*W-1:0] v, eo;
    logic [N*IW-1:0] ei;
    logic [W-1:0] em;
    int pre, lat;
    v = {$urandom, $urandom} & {(N*W){1'b1}};
    model_sort(v, 1'b0, eo, ei, em);
    do_accept(v, 1'b0);
    @(posedge clk);
    pre = 1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      pre++;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        errors++; $display("FAIL stall_hold got %b required 00", {out_valid, in_ready});
      end
    end
    en = 1'b1;
    wait_valid(lat);
    checks++;
    if (pre + lat !== 7) begin errors++; $display("FAIL stall_latency got %0d required 7", pre + lat); end
    checks++;
    if ({out, out_idx, max_out} !== {eo, ei, em}) begin
      errors++; $display("FAIL stall_result got %h/%h/%h required %h/%h/%h",
                         out, out_idx, max_out, eo, ei, em);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [N*W-1:0] v, eo;
    logic [N*IW-1:0] ei;
    logic [W-1:0] em;
    int lat;
    do_accept({8'h11, 8'h44, 8'h22, 8'h33}, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out, out_idx, max_out} !== {1'b0, 1'b1, {(N*W + N*IW + W){1'b0}}}) begin
      errors++; $display("FAIL reset_mid got v%b r%b %h/%h/%h required v0 r1 zeros",
                         out_valid, in_ready, out, out_idx, max_out);
    end
    @(negedge clk);
    rst = 1'b1;
    v = {$urandom, $urandom} & {(N*W){1'b1}};
    model_sort(v, 1'b1, eo, ei, em);
    do_accept(v, 1'b1);
    wait_valid(lat);
    checks++;
    if ({lat, out, out_idx, max_out} !== {32'd4, eo, ei, em}) begin
      errors++; $display("FAIL reset_fresh got lat %0d %h/%h/%h required lat 4 %h/%h/%h",
                         lat, out, out_idx, max_out, eo, ei, em);
    end
    release_out();
  endtask

  task automatic test_signed_compare();
    logic [N*W-1:0] v = {8'h7F, 8'h80, 8'h01, 8'hFF};
    logic [N*W-1:0] eo, req_o;
    logic [N*IW-1:0] ei;
    logic [W-1:0] em, req_m;
    int lat;
`ifdef SORT_SIGNED_EN
    req_o = {8'h7F, 8'h01, 8'hFF, 8'h80};
    req_m = 8'h7F;
`else
    req_o = {8'hFF, 8'h80, 8'h7F, 8'h01};
    req_m = 8'hFF;
`endif
    model_sort(v, 1'b0, eo, ei, em);
    do_accept(v, 1'b0);
    wait_valid(lat);
    checks++;
    if ({out, max_out} !== {req_o, req_m}) begin
      errors++; $display("FAIL sign_out got %h/%h required %h/%h", out, max_out, req_o, req_m);
    end
    checks++;
    if (out_idx !== ei) begin errors++; $display("FAIL sign_idx got %b required %b", out_idx, ei); end
    release_out();
  endtask

  task automatic test_random();
    logic [N*W-1:0] v, eo;
    logic [N*IW-1:0] ei;
    logic [W-1:0] em;
    bit d;
    int lat;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < int'(N); i++)
        v[i*W +: W] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      d = 1'($urandom_range(0, 1));
      model_sort(v, d, eo, ei, em);
      do_accept(v, d);
      wait_valid(lat);
      checks++;
      if ({lat, out, out_idx, max_out} !== {32'd4, eo, ei, em}) begin
        errors++; $display("FAIL random_%0d d%0d in %h got lat %0d %h/%h/%h required lat 4 %h/%h/%h",
                           t, d, v, lat, out, out_idx, max_out, eo, ei, em);
      end
      release_out();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    in_bus = '0;
    desc = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_asc();
    test_desc_ties();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_signed_compare();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
